// File: rtl/cla_mp_pkg.sv
// Shared types and constants for the multi-precision CLA adder sequencer.
package cla_mp_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width; a single-slice build still needs one bit.
    function automatic int unsigned idx_w(input int unsigned words);
        return (words > 1) ? 32'($clog2(words)) : 32'd1;
    endfunction

endpackage

// File: rtl/cla_mp_seq_if.sv
// Start/result handshake bundle for cla_mp_seq.
// The sub signal exists only when CLA_MP_SUB_EN is defined.
interface cla_mp_seq_if
    import cla_mp_pkg::*;
#(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = SLICE_W * WORDS;

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
`ifdef CLA_MP_SUB_EN
    logic         sub;
`endif
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output start_valid, op_a, op_b, cin, res_ready,
`ifdef CLA_MP_SUB_EN
        output sub,
`endif
        input  start_ready, res_valid, result, cout, ovf, busy
    );

    modport slave (
        input  start_valid, op_a, op_b, cin, res_ready,
`ifdef CLA_MP_SUB_EN
        input  sub,
`endif
        output start_ready, res_valid, result, cout, ovf, busy
    );

endinterface

// File: rtl/cla_16.sv
// 16-bit carry look-ahead adder: four 4-bit groups with group generate/propagate.
module CLA_16 (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    logic [15:0] p;
    logic [15:0] g;

    assign p = in1 ^ in2;
    assign g = in1 & in2;

    always_comb begin
        logic [3:0]  gg;
        logic [3:0]  pg;
        logic [4:0]  cb;
        logic [15:0] c;
        gg = '0;
        pg = '0;
        cb = '0;
        c  = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
        end
        // Group carries resolve first, then bit carries inside each group.
        cb[0] = Cin;
        for (int j = 0; j < 4; j++) begin
            cb[j+1] = gg[j] | (pg[j] & cb[j]);
        end
        for (int j = 0; j < 4; j++) begin
            c[4*j] = cb[j];
            for (int i = 1; i < 4; i++) begin
                c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
            end
        end
        Sum  = p ^ c;
        Cout = cb[4];
    end

endmodule

// File: rtl/cla_mp_seq.sv
// Multi-precision adder: one 16-bit slice per cycle through a single CLA_16, LSB slice first.
// Define CLA_MP_SUB_EN to add the sub input (A-B via inverted B and carry-in of 1).
module cla_mp_seq
    import cla_mp_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    cla_mp_seq_if.slave  bus
);

    localparam int unsigned     IDX_W    = idx_w(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t state;
    state_t state_nxt;

    logic [WORDS-1:0][SLICE_W-1:0] a_q;
    logic [WORDS-1:0][SLICE_W-1:0] b_q;
    logic [WORDS-1:0][SLICE_W-1:0] res_q;
    logic [IDX_W-1:0]              idx;
    logic                          carry_q;
    logic                          cout_q;
    logic                          ovf_q;

    logic [SLICE_W-1:0] sum;
    logic               co;
    logic               sub_in;
    logic               accept;
    logic               last;

`ifdef CLA_MP_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept = (state == IDLE) && bus.start_valid;
    assign last   = (idx == LAST_IDX);

    CLA_16 u_cla (
        .in1  (a_q[idx]),
        .in2  (b_q[idx]),
        .Cin  (carry_q),
        .Sum  (sum),
        .Cout (co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start_valid) state_nxt = RUN;
            RUN:     if (last)            state_nxt = DONE;
            DONE:    if (bus.res_ready)   state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Handshake/status decode from the state register
    always_comb begin
        bus.start_ready = 1'b0;
        bus.busy        = 1'b0;
        bus.res_valid   = 1'b0;
        unique case (state)
            IDLE:    bus.start_ready = 1'b1;
            RUN:     bus.busy        = 1'b1;
            DONE:    bus.res_valid   = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and slice-serial datapath; subtraction folds into B and carry-in
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.op_a;
            b_q     <= sub_in ? ~bus.op_b : bus.op_b;
            carry_q <= sub_in ? 1'b1 : bus.cin;
            idx     <= '0;
        end else if (state == RUN) begin
            res_q[idx] <= sum;
            carry_q    <= co;
            if (last) begin
                cout_q <= co;
                ovf_q  <= (a_q[WORDS-1][SLICE_W-1] == b_q[WORDS-1][SLICE_W-1])
                       && (sum[SLICE_W-1] != a_q[WORDS-1][SLICE_W-1]);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_cla_mp_seq.sv
// Directed bench for cla_mp_seq at WORDS=4; subtraction cases run when CLA_MP_SUB_EN is defined.
module tb_cla_mp_seq;

    localparam int unsigned WORDS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cla_mp_seq_if #(.WORDS(WORDS)) bus ();

    cla_mp_seq #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] r;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and return just after its accepting edge.
    task automatic start_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                            input logic c, input logic s);
        int w;
        w = 0;
        while (!bus.start_ready && w < 20) begin
            step();
            w++;
        end
        if (w >= 20) chk({nm, ".start_ready_timeout"}, 64'(bus.start_ready), 64'd1);
        bus.op_a        = a;
        bus.op_b        = b;
        bus.cin         = c;
`ifdef CLA_MP_SUB_EN
        bus.sub         = s;
`else
        if (s) $display("sub request ignored without subtract support");
`endif
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic s,
                          input logic [63:0] er, input logic eco, input logic eov);
        int cyc;
        int busy_n;
        start_op(nm, a, b, c, s);
        cyc    = 0;
        busy_n = 0;
        while (!bus.res_valid && cyc < 20) begin
            if (bus.busy) busy_n++;
            step();
            cyc++;
        end
        chk({nm, ".latency"}, 64'(cyc), 64'(WORDS));
        chk({nm, ".busy_cycles"}, 64'(busy_n), 64'(WORDS));
        chk({nm, ".result"}, bus.result, er);
        chk({nm, ".cout"}, 64'(bus.cout), 64'(eco));
        chk({nm, ".ovf"}, 64'(bus.ovf), 64'(eov));
        step();
        chk({nm, ".res_valid_drop"}, 64'(bus.res_valid), 64'd0);
        chk({nm, ".start_ready_back"}, 64'(bus.start_ready), 64'd1);
    endtask

    initial begin
        int w;
        bus.start_valid = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.cin         = 1'b0;
        bus.res_ready   = 1'b1;
`ifdef CLA_MP_SUB_EN
        bus.sub         = 1'b0;
`endif

        vecs[0] = '{"small",     64'd12,                  64'd17,                  1'b0, 64'd29,                  1'b0, 1'b0};
        vecs[1] = '{"ripple",    64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   1'b0, 64'd0,                   1'b1, 1'b0};
        vecs[2] = '{"pos_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                   1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{"cin_in",    64'd780,                 64'd7800,                1'b1, 64'd8581,                1'b0, 1'b0};
        vecs[4] = '{"neg_ovf",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0,                   1'b1, 1'b1};
        vecs[5] = '{"part_rip",  64'h0001_0000_FFFF_FFFF, 64'd1,                   1'b0, 64'h0001_0001_0000_0000, 1'b0, 1'b0};
        vecs[6] = '{"neg1_neg1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{"mixed",     64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};

        repeat (3) step();
        chk("rst.start_ready", 64'(bus.start_ready), 64'd1);
        chk("rst.res_valid",   64'(bus.res_valid),   64'd0);
        chk("rst.busy",        64'(bus.busy),        64'd0);
        chk("rst.result",      bus.result,           64'd0);
        chk("rst.cout",        64'(bus.cout),        64'd0);
        chk("rst.ovf",         64'(bus.ovf),         64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                   vecs[i].r, vecs[i].co, vecs[i].ov);
        end

        // Backpressure in DONE with a start pulse that must be ignored
        bus.res_ready = 1'b0;
        start_op("bp", 64'd780, 64'd7800, 1'b1, 1'b0);
        w = 0;
        while (!bus.res_valid && w < 20) begin
            step();
            w++;
        end
        chk("bp.res_valid_rise", 64'(bus.res_valid), 64'd1);
        chk("bp.result", bus.result, 64'd8581);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.op_a        = 64'd111;
                bus.op_b        = 64'd222;
                bus.start_valid = 1'b1;
            end else begin
                bus.start_valid = 1'b0;
            end
            step();
            chk($sformatf("bp.hold_valid[%0d]", i), 64'(bus.res_valid),   64'd1);
            chk($sformatf("bp.hold_ready[%0d]", i), 64'(bus.start_ready), 64'd0);
            chk($sformatf("bp.hold_res[%0d]", i),   bus.result,            64'd8581);
        end
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;
        step();
        chk("bp.release_valid", 64'(bus.res_valid),   64'd0);
        chk("bp.release_ready", 64'(bus.start_ready), 64'd1);
        chk("bp.release_res",   bus.result,           64'd8581);
        step();
        chk("bp.no_queue_busy", 64'(bus.busy), 64'd0);

        // Reset during the second RUN cycle discards the partial sum
        start_op("mid_rst", 64'd65535, 64'd1, 1'b0, 1'b0);
        step();
        chk("mid_rst.in_run", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst.start_ready", 64'(bus.start_ready), 64'd1);
        chk("mid_rst.res_valid",   64'(bus.res_valid),   64'd0);
        chk("mid_rst.busy",        64'(bus.busy),        64'd0);
        chk("mid_rst.result",      bus.result,           64'd0);
        chk("mid_rst.cout",        64'(bus.cout),        64'd0);
        run_op("after_rst", 64'd65535, 64'd1, 1'b1, 1'b0, 64'd65537, 1'b0, 1'b0);

`ifdef CLA_MP_SUB_EN
        run_op("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_7_5", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2,                   1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cla_mp_seq.md
Name: cla_mp_seq

Overview:
- Multi-precision adder sequencer built around the existing CLA_16 carry look-ahead adder.
- Accepts WORDS×16-bit operands over a valid/ready handshake.
- Feeds one 16-bit slice per cycle, least-significant slice first, through a single CLA_16 instance, chaining the carry through a register.
- Returns the full sum, carry-out and signed-overflow flag over a second valid/ready handshake.

Parameters:
- WORDS, 4, number of 16-bit slices per operand; legal range 1..16; operand width W = 16*WORDS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  operands and cin valid.
- start_ready  out  1  block can accept a new operation.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- cin  in  1  carry into slice 0.
- res_valid  out  1  result, cout and ovf valid.
- res_ready  in  1  consumer accepts the result.
- result  out  W  sum, registered.
- cout  out  1  carry out of slice WORDS-1.
- ovf  out  1  two's-complement overflow of the W-bit add.
- busy  out  1  high in RUN state.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, start_ready=1, res_valid=0, busy=0, result=0, cout=0, ovf=0, slice index=0, carry register=0.
- State IDLE:
  - start_ready=1.
  - On start_valid at a clock edge: latch op_a, op_b into operand registers; carry_reg<=cin; idx<=0; go to RUN.
- State RUN:
  - busy=1, start_ready=0.
  - CLA_16 inputs: in1=A[idx*16+:16], in2=B[idx*16+:16], Cin=carry_reg.
  - Each edge: result[idx*16+:16]<=Sum; carry_reg<=Cout; idx<=idx+1.
  - On the edge that writes slice WORDS-1: cout<=Cout; ovf<=(A[W-1]==B[W-1]) && (Sum[15]!=A[W-1]); go to DONE.
- State DONE:
  - res_valid=1; result, cout and ovf held stable.
  - On res_ready: go to IDLE; res_valid falls on the next cycle.
  - result, cout and ovf keep their values after the handoff until the next operation overwrites them.
- Latency:
  - Start accepted at edge k gives res_valid=1 after edge k+WORDS.
  - Minimum issue interval is WORDS+2 cycles when res_ready is tied high.
- start_valid is ignored outside IDLE, since start_ready=0 there. No queuing.
- WORDS=1: exactly one RUN cycle.
- idx is a counter of max(1, clog2(WORDS)) bits. It never wraps because the RUN exit occurs at WORDS-1.
- Input operands are sampled only at acceptance. Changes to op_a, op_b or cin afterwards have no effect.
- The result register is updated slice by slice during RUN. Its value is only meaningful while res_valid=1.
- rst asserted in any state, including mid-RUN or DONE under backpressure:
  - Next cycle all outputs and state take their reset values.
  - The partial result is discarded.
  - rst has priority over start_valid and res_ready in the same cycle.

Optional Feature:
- Macro: CLA_MP_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - sub=1 computes A-B: the B register latches ~op_b and carry_reg is initialised to 1; cin is ignored.
  - ovf is computed using the latched inverted B.
  - cout=1 means no borrow.
- Undefined:
  - No sub port; addition only.
  - Behaviour is identical to the base description.

Decomposition:
- Shared package cla_mp_pkg holds:
  - SLICE_W=16.
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function computing idx width from WORDS.
- Sub-module: the existing CLA_16, instantiated once with ports in1/in2/Cin/Sum/Cout. No new sub-module is needed.
- All sequencing lives in cla_mp_seq.

Test Plan (WORDS=4):
1. op_a=12, op_b=17, cin=0, res_ready=1 -> result=29, cout=0, ovf=0; res_valid rises exactly 4 cycles after the accepting edge; busy high for 4 cycles.
2. op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=1, cin=0 -> result=0, cout=1, ovf=0; carry ripples through all 4 slices.
3. op_a=64'h7FFF_FFFF_FFFF_FFFF, op_b=1, cin=0 -> result=64'h8000_0000_0000_0000, cout=0, ovf=1.
4. op_a=780, op_b=7800, cin=1, res_ready held 0 for 10 cycles, start_valid pulsed with different operands during DONE:
   - res_valid stays 1 and result=8581 stays stable.
   - start_ready=0 throughout; the pulsed operands are not accepted.
   - After res_ready=1: IDLE next cycle, start_ready=1.
5. rst asserted during the second RUN cycle of op_a=65535, op_b=1 -> next cycle state IDLE, result=0, res_valid=0, start_ready=1; a following op_a=65535, op_b=1, cin=1 -> result=65537, cout=0.
6. With CLA_MP_SUB_EN: op_a=5, op_b=7, sub=1 -> result=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; op_a=7, op_b=5, sub=1 -> result=2, cout=1.
